// File: rtl/execute_stage_if.sv
// ID/EX -> execute stage -> EX/MEM signal bundle.
// The master drives the ID/EX fields. The slave is the execute stage.
interface execute_stage_if;
  logic [31:0] pcAdded;
  logic [31:0] Read1;
  logic [31:0] Read2;
  logic [31:0] i16_0Extended;
  logic [4:0]  i20_16;
  logic [4:0]  i15_11;
  logic        regDst;
  logic        aluSrc;
  logic        branch;
  logic        memWrite;
  logic        memRead;
  logic        regWrite;
  logic        memToReg;
  logic [2:0]  aluOp;

  logic [31:0] outBranchTarget;
  logic [31:0] outAluResult;
  logic        outZero;
  logic [31:0] outRead2;
  logic [4:0]  outWriteReg;
  logic        outBranch;
  logic        outMemWrite;
  logic        outMemRead;
  logic        outRegWrite;
  logic        outMemToReg;
  logic        exBusy;

  modport master (
    output pcAdded, Read1, Read2, i16_0Extended, i20_16, i15_11,
           regDst, aluSrc, branch, memWrite, memRead, regWrite, memToReg, aluOp,
    input  outBranchTarget, outAluResult, outZero, outRead2, outWriteReg,
           outBranch, outMemWrite, outMemRead, outRegWrite, outMemToReg, exBusy
  );

  modport slave (
    input  pcAdded, Read1, Read2, i16_0Extended, i20_16, i15_11,
           regDst, aluSrc, branch, memWrite, memRead, regWrite, memToReg, aluOp,
    output outBranchTarget, outAluResult, outZero, outRead2, outWriteReg,
           outBranch, outMemWrite, outMemRead, outRegWrite, outMemToReg, exBusy
  );
endinterface

// File: rtl/execute_stage.sv
// MIPS execute stage: this block computes the ALU result and the branch target and registers them into EX/MEM.
// Defining EX_MULT_EN adds a 32-cycle shift-add multiplier for funct 011000.
module execute_stage (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  execute_stage_if.slave ex
);

  typedef struct packed {
    logic [31:0] branchTarget;
    logic [31:0] aluResult;
    logic        zero;
    logic [31:0] read2;
    logic [4:0]  writeReg;
    logic        branch;
    logic        memWrite;
    logic        memRead;
    logic        regWrite;
    logic        memToReg;
  } exMemT;

  exMemT       exMemQ;
  exMemT       loadVal;
  logic [31:0] opB;
  logic [5:0]  funct;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] sltRes;
  logic [31:0] aluResult;

  always_comb begin
    opB    = ex.aluSrc ? ex.i16_0Extended : ex.Read2;
    funct  = ex.i16_0Extended[5:0];
    sum    = ex.Read1 + opB;
    diff   = ex.Read1 - opB;
    sltRes = {31'b0, ($signed(ex.Read1) < $signed(opB))};

    aluResult = '0;
    case (ex.aluOp)
      3'b000:  aluResult = sum;
      3'b001:  aluResult = diff;
      3'b011:  aluResult = ex.Read1 & opB;
      3'b100:  aluResult = ex.Read1 | opB;
      3'b101:  aluResult = sltRes;
      3'b010: begin
        case (funct)
          6'b100000: aluResult = sum;
          6'b100010: aluResult = diff;
          6'b100100: aluResult = ex.Read1 & opB;
          6'b100101: aluResult = ex.Read1 | opB;
          6'b101010: aluResult = sltRes;
          default:   aluResult = '0;
        endcase
      end
      default: aluResult = '0;
    endcase

    loadVal              = '0;
    loadVal.branchTarget = ex.pcAdded + (ex.i16_0Extended << 2);
    loadVal.aluResult    = aluResult;
    loadVal.zero         = (aluResult == 32'd0);
    loadVal.read2        = ex.Read2;
    loadVal.writeReg     = ex.regDst ? ex.i15_11 : ex.i20_16;
    loadVal.branch       = ex.branch;
    loadVal.memWrite     = ex.memWrite;
    loadVal.memRead      = ex.memRead;
    loadVal.regWrite     = ex.regWrite;
    loadVal.memToReg     = ex.memToReg;
  end

`ifdef EX_MULT_EN
  typedef enum logic [1:0] {StIdle, StMul, StDone} mulStateT;

  mulStateT    mulState;
  logic [5:0]  mulCount;
  logic [31:0] mulAcc;
  logic [31:0] mulMcand;
  logic [31:0] mulMplier;
  exMemT       mulHold;
  exMemT       mulCapture;
  logic        multDecoded;

  assign multDecoded = (ex.aluOp == 3'b010) && (funct == 6'b011000);

  // Only the low 32 product bits are kept, so a 32-bit accumulator is exact.
  always_comb begin
    mulCapture           = mulHold;
    mulCapture.aluResult = mulAcc;
    mulCapture.zero      = (mulAcc == 32'd0);
  end

  assign ex.exBusy = ((mulState == StIdle) && multDecoded) || (mulState == StMul);

  always_ff @(posedge clk) begin
    if (rst) begin
      exMemQ    <= '0;
      mulState  <= StIdle;
      mulCount  <= '0;
      mulAcc    <= '0;
      mulMcand  <= '0;
      mulMplier <= '0;
      mulHold   <= '0;
    end else if (flush) begin
      exMemQ   <= '0;
      mulState <= StIdle;
    end else begin
      case (mulState)
        StIdle: begin
          if (!stall) begin
            if (multDecoded) begin
              exMemQ    <= '0;
              mulHold   <= loadVal;
              mulAcc    <= '0;
              mulMcand  <= ex.Read1;
              mulMplier <= opB;
              mulCount  <= '0;
              mulState  <= StMul;
            end else begin
              exMemQ <= loadVal;
            end
          end
        end
        StMul: begin
          // The multiplier keeps iterating under stall; only EX/MEM holds.
          if (!stall) exMemQ <= '0;
          mulAcc    <= mulAcc + (mulMplier[0] ? mulMcand : 32'd0);
          mulMcand  <= mulMcand << 1;
          mulMplier <= mulMplier >> 1;
          mulCount  <= mulCount + 6'd1;
          if (mulCount == 6'd31) mulState <= StDone;
        end
        StDone: begin
          if (!stall) begin
            exMemQ   <= mulCapture;
            mulState <= StIdle;
          end
        end
        default: mulState <= StIdle;
      endcase
    end
  end
`else
  assign ex.exBusy = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      exMemQ <= '0;
    end else if (flush) begin
      exMemQ <= '0;
    end else if (!stall) begin
      exMemQ <= loadVal;
    end
  end
`endif

  assign ex.outBranchTarget = exMemQ.branchTarget;
  assign ex.outAluResult    = exMemQ.aluResult;
  assign ex.outZero         = exMemQ.zero;
  assign ex.outRead2        = exMemQ.read2;
  assign ex.outWriteReg     = exMemQ.writeReg;
  assign ex.outBranch       = exMemQ.branch;
  assign ex.outMemWrite     = exMemQ.memWrite;
  assign ex.outMemRead      = exMemQ.memRead;
  assign ex.outRegWrite     = exMemQ.regWrite;
  assign ex.outMemToReg     = exMemQ.memToReg;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage. The stimulus is a linear series of steps with hand-computed expectations.
// The multiplier steps are built only when EX_MULT_EN is defined.
module tb_execute_stage;
  logic clk = 1'b0;
  logic rst;
  logic stall;
  logic flush;
  int   tests = 0;
  int   fails = 0;
  int   busyCnt;

  execute_stage_if bus ();

  execute_stage dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .flush (flush),
    .ex    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setOp(input logic [2:0] op, input logic src, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] imm);
    bus.aluOp         = op;
    bus.aluSrc        = src;
    bus.Read1         = r1;
    bus.Read2         = r2;
    bus.i16_0Extended = imm;
  endtask

  task automatic chkBubble(input string tag);
    chk({tag, "_res"}, bus.outAluResult, 32'd0);
    chk({tag, "_ctl"}, 32'({bus.outBranch, bus.outMemWrite, bus.outMemRead,
                            bus.outRegWrite, bus.outMemToReg, bus.outZero}), 32'd0);
    chk({tag, "_bt"}, bus.outBranchTarget, 32'd0);
    chk({tag, "_wr"}, 32'(bus.outWriteReg), 32'd0);
    chk({tag, "_r2"}, bus.outRead2, 32'd0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    bus.pcAdded = 32'd0; bus.i20_16 = 5'd3; bus.i15_11 = 5'd9;
    bus.regDst = 1'b1; bus.branch = 1'b0; bus.memWrite = 1'b0; bus.memRead = 1'b0;
    bus.regWrite = 1'b1; bus.memToReg = 1'b0;
    setOp(3'b010, 1'b0, 32'd5, 32'd7, 32'h22);
    tick();
    chkBubble("reset");
    chk("reset_busy", 32'(bus.exBusy), 32'd0);
    rst = 1'b0;

    // R-type sub: 5 - 7
    tick();
    chk("sub_res", bus.outAluResult, 32'hFFFF_FFFE);
    chk("sub_zero", 32'(bus.outZero), 32'd0);
    chk("sub_wr", 32'(bus.outWriteReg), 32'd9);
    chk("sub_rw", 32'(bus.outRegWrite), 32'd1);
    chk("sub_r2", bus.outRead2, 32'd7);
    chk("sub_bt", bus.outBranchTarget, 32'h88);

    setOp(3'b010, 1'b0, 32'd5, 32'd7, 32'h2A);
    tick();
    chk("slt_res", bus.outAluResult, 32'd1);
    setOp(3'b101, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    tick();
    chk("slt_neg", bus.outAluResult, 32'd1);
    setOp(3'b101, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0);
    tick();
    chk("slt_pos", bus.outAluResult, 32'd0);
    chk("slt_pos_zero", 32'(bus.outZero), 32'd1);

    // Immediate add wrapping to zero, rt as destination
    bus.regDst = 1'b0;
    setOp(3'b000, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd1);
    tick();
    chk("addi_res", bus.outAluResult, 32'd0);
    chk("addi_zero", 32'(bus.outZero), 32'd1);
    chk("addi_wr", 32'(bus.outWriteReg), 32'd3);

    bus.pcAdded = 32'd100; bus.branch = 1'b1;
    setOp(3'b000, 1'b1, 32'd0, 32'd0, 32'hFFFF_FFFF);
    tick();
    chk("bt_wrap", bus.outBranchTarget, 32'd96);
    chk("bt_res", bus.outAluResult, 32'hFFFF_FFFF);
    chk("bt_branch", 32'(bus.outBranch), 32'd1);
    bus.branch = 1'b0; bus.pcAdded = 32'd0;

    setOp(3'b011, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0);
    tick();
    chk("and_res", bus.outAluResult, 32'h00F0);
    setOp(3'b100, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0);
    tick();
    chk("or_res", bus.outAluResult, 32'hFFF0);
    setOp(3'b001, 1'b0, 32'd9, 32'd4, 32'd0);
    tick();
    chk("sub1_res", bus.outAluResult, 32'd5);
    setOp(3'b110, 1'b0, 32'd9, 32'd4, 32'd0);
    tick();
    chk("op110_res", bus.outAluResult, 32'd0);
    setOp(3'b010, 1'b0, 32'd9, 32'd4, 32'h3F);
    tick();
    chk("badfunct_res", bus.outAluResult, 32'd0);
    setOp(3'b010, 1'b0, 32'd9, 32'd4, 32'h20);
    tick();
    chk("radd_res", bus.outAluResult, 32'd13);
`ifndef EX_MULT_EN
    setOp(3'b010, 1'b0, 32'd6, 32'd7, 32'h18);
    #1;
    chk("nomult_busy", 32'(bus.exBusy), 32'd0);
    tick();
    chk("nomult_res", bus.outAluResult, 32'd0);
`endif

    // Mid-stream reset with live inputs
    setOp(3'b000, 1'b0, 32'd1, 32'd2, 32'd0);
    bus.memRead = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chkBubble("midrst");
    chk("midrst_busy", 32'(bus.exBusy), 32'd0);
    bus.memRead = 1'b0;

    // Stall holds EX/MEM while the inputs change
    setOp(3'b000, 1'b0, 32'd10, 32'd20, 32'd0);
    tick();
    chk("prestall_res", bus.outAluResult, 32'd30);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      setOp(3'b001, 1'b1, 32'd100 + 32'(i), 32'd1, 32'd50);
      bus.regDst = ~bus.regDst;
      tick();
      chk("stall_res", bus.outAluResult, 32'd30);
      chk("stall_r2", bus.outRead2, 32'd20);
    end
    stall = 1'b0;
    tick();
    chk("unstall_res", bus.outAluResult, 32'd52);

    // Flush beats stall and clears regWrite
    bus.regWrite = 1'b1; bus.memWrite = 1'b1;
    flush = 1'b1; stall = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0;
    chkBubble("flush");
    bus.memWrite = 1'b0;

`ifdef EX_MULT_EN
    // 6 x 7 through the multiplier, with rd as the destination
    bus.regDst = 1'b1; bus.i15_11 = 5'd17;
    setOp(3'b010, 1'b0, 32'd6, 32'd7, 32'h18);
    #1;
    busyCnt = 0;
    if (bus.exBusy) busyCnt++;
    for (int k = 0; k <= 32; k++) begin
      tick();
      chk("mul_bubble_res", bus.outAluResult, 32'd0);
      chk("mul_bubble_rw", 32'(bus.outRegWrite), 32'd0);
      if (k < 32 && bus.exBusy) busyCnt++;
    end
    chk("mul_busy_cycles", 32'(busyCnt), 32'd33);
    chk("mul_done_busy", 32'(bus.exBusy), 32'd0);
    tick();
    chk("mul_res", bus.outAluResult, 32'd42);
    chk("mul_wr", 32'(bus.outWriteReg), 32'd17);
    chk("mul_rw", 32'(bus.outRegWrite), 32'd1);

    // Abort a multiply at count 10
    setOp(3'b010, 1'b0, 32'd6, 32'd7, 32'h18);
    for (int k = 0; k <= 10; k++) tick();
    chk("abort_busy_pre", 32'(bus.exBusy), 32'd1);
    flush = 1'b1;
    setOp(3'b000, 1'b0, 32'd2, 32'd3, 32'd0);
    tick();
    flush = 1'b0;
    chk("abort_busy", 32'(bus.exBusy), 32'd0);
    chk("abort_res", bus.outAluResult, 32'd0);
    tick();
    chk("abort_next_add", bus.outAluResult, 32'd5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
